// File: rtl/lsu_pkg.sv
`default_nettype none
//==============================================================================
// Package     : lsu_pkg
// Description : Shared constants, state encoding and legality check for the
//               RV32I load/store unit.
// Revision    : 1.0 - initial release
//==============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_DONE   = 2'b10
    } lsu_state_e;

    // Unsigned widths exist only for loads; alignment follows the access size.
    function automatic logic lsu_legal(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~offset[0];
            F3_W:    ok = (offset == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
//==============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/halfword of a read word and sign- or
//               zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
//==============================================================================
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = rdata[{offset, 3'b000} +: 8];
        w_half   = rdata[{offset[1], 4'b0000} +: 16];
        ext_data = rdata;
        case (funct3)
            F3_B:    ext_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    ext_data = {{16{w_half[15]}}, w_half};
            F3_BU:   ext_data = {24'h000000, w_byte};
            F3_HU:   ext_data = {16'h0000, w_half};
            default: ext_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
//==============================================================================
// Module      : load_store_unit
// Description : RV32I memory-access stage: alignment check, word-addressed
//               request/ready memory port, extended load result.
// Revision    : 1.0 - initial release
//==============================================================================
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err
);

    lsu_state_e  r_state, w_state_nxt;
    logic        r_is_store, w_is_store_nxt;
    logic [2:0]  r_funct3, w_funct3_nxt;
    logic [1:0]  r_offset, w_offset_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]  r_mem_wstrb, w_mem_wstrb_nxt;
    logic [31:0] r_load_data, w_load_data_nxt;
    logic        r_err, w_err_nxt;

    logic [31:0] w_lane_data;
    logic [3:0]  w_lane_strb;
    logic [31:0] w_ext;

    load_extend u_load_extend (
        .rdata    (mem_rdata),
        .offset   (r_offset),
        .funct3   (r_funct3),
        .ext_data (w_ext)
    );

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                w_lane_data = {4{wdata[7:0]}};
                w_lane_strb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_lane_data = {2{wdata[15:0]}};
                w_lane_strb = 4'b0011 << addr[1:0];
            end
            default: begin
                w_lane_data = wdata;
                w_lane_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_is_store_nxt  = r_is_store;
        w_funct3_nxt    = r_funct3;
        w_offset_nxt    = r_offset;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        w_load_data_nxt = r_load_data;
        w_err_nxt       = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_is_store_nxt = is_store;
                    w_funct3_nxt   = funct3;
                    w_offset_nxt   = addr[1:0];
                    if (!lsu_legal(is_store, funct3, addr[1:0])) begin
                        w_state_nxt     = S_DONE;
                        w_err_nxt       = 1'b1;
                        w_load_data_nxt = 32'h0;
                    end else begin
                        w_state_nxt     = S_ACCESS;
                        w_mem_addr_nxt  = {addr[31:2], 2'b00};
                        w_mem_wdata_nxt = w_lane_data;
                        w_mem_wstrb_nxt = is_store ? w_lane_strb : 4'b0000;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b0;
                    if (!r_is_store) begin
                        w_load_data_nxt = w_ext;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_offset    <= 2'b00;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'b0000;
            r_load_data <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_is_store  <= w_is_store_nxt;
            r_funct3    <= w_funct3_nxt;
            r_offset    <= w_offset_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
            r_load_data <= w_load_data_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Control outputs are pure decodes of the state register.
    assign mem_req   = (r_state == S_ACCESS);
    assign mem_we    = (r_state == S_ACCESS) & r_is_store;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign load_data = r_load_data;
    assign err       = r_err;

endmodule
`default_nettype wire
